l1_icache_refill_ctrl: RTL and testbench
========================================

// Module: l1_icache_refill_ctrl
// PURPOSE
//  Miss/refill controller for the 64 KB 8-way L1 I-cache.
//  - Accepts line misses from both fetch ports (if1, if2) and merges same-line misses.
//  - Queues misses in a FIFO-ordered MSHR.
//  - Issues one line request at a time to L2.
//  - Sequences the returning beats into the cache data/tag array write port, then signals fill completion.
// PARAMETERS
//  LINE_BYTES   64  cache line size; BEATS = LINE_BYTES/8 = 8 beats of 64 bits
//  ASSOC        8   ways; WAY_BITS = $clog2(ASSOC)
//  INDEX_BITS   7   set index width (128 sets)
//  OFFSET_BITS  6   line offset width
//  TAG_BITS     51  tag width = 64-INDEX_BITS-OFFSET_BITS
//  MSHR_ENTRIES 4   outstanding distinct line misses (>=2)
// PORTS
//  clk             in   1          clock
//  rst_n           in   1          async active-low reset
//  miss_valid_if1  in   1          port-1 miss request
//  miss_addr_if1   in   64         port-1 miss byte address
//  miss_ready_if1  out  1          port-1 miss accepted this cycle when valid&ready
//  miss_valid_if2  in   1          port-2 miss request
//  miss_addr_if2   in   64         port-2 miss byte address
//  miss_ready_if2  out  1          port-2 accept
//  l2_req_valid    out  1          line request to L2
//  l2_req_addr     out  64         line-aligned address (low OFFSET_BITS zero)
//  l2_req_ready    in   1          L2 accepts request
//  l2_resp_valid   in   1          refill beat valid (no backpressure)
//  l2_resp_data    in   64         refill beat data, beat 0 = lowest address
//  l2_resp_last    in   1          final beat marker
//  fill_valid      out  1          write one 64-bit word into the array
//  fill_set        out  INDEX_BITS target set
//  fill_way        out  WAY_BITS   victim way
//  fill_word       out  3          word within line (= beat number)
//  fill_tag        out  TAG_BITS   tag to install with the line
//  fill_data       out  64         word data
//  fill_done       out  1          one-cycle pulse: line installed
//  fill_done_addr  out  64         line-aligned address of the completed line
//  busy            out  1          MSHR non-empty or FSM not IDLE
// BEHAVIOUR
//  - Reset: every output 0, MSHR empty, FSM=IDLE, beat cnt=0, victim ptr=0.
//    Reset mid-refill abandons the line; L2 shares rst_n, so no stale beats.
//  - Merge: a miss whose line addr matches a valid MSHR entry or the in-flight line is accepted with no new entry.
//    if1 and if2 on the same line in one cycle allocate one entry.
//  - Ready: ready_if1 = !full | merge_if1.
//    ready_if2 = (free>=2) | (free==1 & !alloc_if1) | merge_if2 | same-line-as-if1.
//    if1 has priority on the last free slot.
//  - Allocation order: if1 before if2 in the same cycle. Entries are line-aligned addresses.
//  - FSM IDLE->REQ when MSHR non-empty; the head entry drives l2_req_addr.
//    Latency: miss at cycle N gives l2_req_valid at N+2.
//  - REQ: l2_req_valid=1 until l2_req_ready; handshake -> FILL. Address stable while valid.
//  - FILL: each l2_resp_valid beat gives fill_valid=1 the same cycle, with
//    fill_data=l2_resp_data, fill_word=cnt, fill_set/fill_tag from the head entry, and fill_way=victim ptr.
//    cnt increments and wraps after BEATS-1. The beat with cnt==BEATS-1 -> DONE.
//  - l2_resp_last must coincide with cnt==BEATS-1 (assertion); the counter, not last, ends the fill.
//  - l2_resp_valid outside FILL is ignored (assertion fires).
//  - DONE (1 cycle): fill_done=1, fill_done_addr=head line; pop the head and advance the victim ptr (mod ASSOC).
//    Next state is REQ if the MSHR is still non-empty, else IDLE.
//  - An allocation and a pop in the same cycle are both honoured; the count stays unchanged.
//  - Misses merging into the in-flight line during DONE are still dropped as merged; the fetch unit replays them.
// STRUCTURE
//  - Shared package l1i_pkg:
//    - LINE_BYTES, OFFSET_BITS, INDEX_BITS, TAG_BITS, BEATS constants.
//    - typedef enum {IDLE,REQ,FILL,DONE} refill_state_e.
//    - typedef struct {valid, line_addr} mshr_entry_t.
//  - Sub-module l1i_mshr_fifo:
//    - MSHR_ENTRIES circular buffer with 2 push ports and 1 pop.
//    - Outputs: head, full, free-count, CAM match vectors for two lookup addresses.
//  - The FSM, beat counter and victim pointer live in the top.
// TESTING
//  - Single miss if1 @0x1040: l2_req_addr=0x1040 at N+2; 8 beats D0..D7 -> fill_word 0..7, fill_set=0x41,
//    fill_way=0; fill_done_addr=0x1040, then IDLE.
//  - if1=0x2000, if2=0x2038 same cycle: one entry, one L2 request; both readies=1.
//  - Fill MSHR with 4 lines; 5th distinct miss: ready=0 until the first fill_done; a miss to a queued line is accepted.
//  - Back-to-back lines A,B: fill_way 0 then 1; B's request issued the cycle after A's fill_done.
//  - l2_req_ready held low 10 cycles: req valid/addr stable; no fill_valid.
//  - Assert rst_n low at beat 3: all outputs 0 next cycle; after reset, a new miss is served correctly.

Source files
------------

// File: rtl/l1i_pkg.sv
// Shared constants, types and helpers for the L1 I-cache refill path.
package l1i_pkg;

    localparam int unsigned ADDR_BITS    = 64;
    localparam int unsigned LINE_BYTES   = 64;
    localparam int unsigned OFFSET_BITS  = 6;
    localparam int unsigned INDEX_BITS   = 7;
    localparam int unsigned TAG_BITS     = ADDR_BITS - INDEX_BITS - OFFSET_BITS;
    localparam int unsigned BEATS        = LINE_BYTES / 8;
    localparam int unsigned BEAT_BITS    = $clog2(BEATS);
    localparam int unsigned ASSOC        = 8;
    localparam int unsigned WAY_BITS     = $clog2(ASSOC);
    localparam int unsigned MSHR_ENTRIES = 4;
    localparam int unsigned CNT_BITS     = $clog2(MSHR_ENTRIES + 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} refill_state_e;

    typedef struct packed {
        logic                 valid;
        logic [ADDR_BITS-1:0] line_addr;
    } mshr_entry_t;

    function automatic logic [ADDR_BITS-1:0] line_of(input logic [ADDR_BITS-1:0] addr);
        return {addr[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l1i_mshr_fifo.sv
// FIFO-ordered miss status holding registers: two push ports, one pop,
// plus a CAM lookup of two line addresses against all valid entries.
module l1i_mshr_fifo
    import l1i_pkg::*;
#(
    parameter int unsigned ENTRIES = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push_a,
    input  logic [ADDR_BITS-1:0]           push_a_addr,
    input  logic                           push_b,
    input  logic [ADDR_BITS-1:0]           push_b_addr,
    input  logic                           pop,
    input  logic [ADDR_BITS-1:0]           lookup_a,
    input  logic [ADDR_BITS-1:0]           lookup_b,
    output mshr_entry_t                    head,
    output logic                           full,
    output logic [$clog2(ENTRIES+1)-1:0]   free_cnt,
    output logic [ENTRIES-1:0]             match_a,
    output logic [ENTRIES-1:0]             match_b
);

    localparam int unsigned PTR_BITS = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned CNT_W    = $clog2(ENTRIES + 1);

    mshr_entry_t           slots [ENTRIES];
    logic [PTR_BITS-1:0]   rd_ptr;
    logic [PTR_BITS-1:0]   wr_ptr;
    logic [CNT_W-1:0]      count;

    function automatic logic [PTR_BITS-1:0] next_ptr(input logic [PTR_BITS-1:0] p);
        return (p == PTR_BITS'(ENTRIES - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) slots[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop) begin
                slots[rd_ptr].valid <= 1'b0;
                rd_ptr              <= next_ptr(rd_ptr);
            end
            // push_b lands behind push_a when both allocate in the same cycle
            if (push_a) slots[wr_ptr] <= '{valid: 1'b1, line_addr: push_a_addr};
            if (push_b) slots[push_a ? next_ptr(wr_ptr) : wr_ptr] <= '{valid: 1'b1, line_addr: push_b_addr};
            if (push_a && push_b)      wr_ptr <= next_ptr(next_ptr(wr_ptr));
            else if (push_a || push_b) wr_ptr <= next_ptr(wr_ptr);
            count <= count + CNT_W'(push_a) + CNT_W'(push_b) - CNT_W'(pop);
        end
    end

    always_comb begin
        head.valid     = slots[rd_ptr].valid;
        head.line_addr = slots[rd_ptr].valid ? slots[rd_ptr].line_addr : '0;
        full           = (count == CNT_W'(ENTRIES));
        free_cnt       = CNT_W'(ENTRIES) - count;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            match_a[i] = slots[i].valid && (slots[i].line_addr == lookup_a);
            match_b[i] = slots[i].valid && (slots[i].line_addr == lookup_b);
        end
    end

endmodule

// File: rtl/l1_icache_refill_ctrl.sv
// L1 I-cache miss/refill controller: merges fetch-port misses, queues them,
// requests lines from L2 one at a time and sequences beats into the array.
module l1_icache_refill_ctrl
    import l1i_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   miss_valid_if1,
    input  logic [ADDR_BITS-1:0]   miss_addr_if1,
    output logic                   miss_ready_if1,
    input  logic                   miss_valid_if2,
    input  logic [ADDR_BITS-1:0]   miss_addr_if2,
    output logic                   miss_ready_if2,
    output logic                   l2_req_valid,
    output logic [ADDR_BITS-1:0]   l2_req_addr,
    input  logic                   l2_req_ready,
    input  logic                   l2_resp_valid,
    input  logic [63:0]            l2_resp_data,
    input  logic                   l2_resp_last,
    output logic                   fill_valid,
    output logic [INDEX_BITS-1:0]  fill_set,
    output logic [WAY_BITS-1:0]    fill_way,
    output logic [BEAT_BITS-1:0]   fill_word,
    output logic [TAG_BITS-1:0]    fill_tag,
    output logic [63:0]            fill_data,
    output logic                   fill_done,
    output logic [ADDR_BITS-1:0]   fill_done_addr,
    output logic                   busy
);

    logic [ADDR_BITS-1:0]     line_if1;
    logic [ADDR_BITS-1:0]     line_if2;
    mshr_entry_t              head;
    logic                     full;
    logic [CNT_BITS-1:0]      free_cnt;
    logic [MSHR_ENTRIES-1:0]  match_if1;
    logic [MSHR_ENTRIES-1:0]  match_if2;
    logic                     merge_if1;
    logic                     merge_if2;
    logic                     same_line;
    logic                     take_if1;
    logic                     alloc_if1;
    logic                     alloc_if2;
    logic                     more_after_pop;
    logic                     pop;
    logic                     beat;
    logic                     running;
    refill_state_e            state;
    logic [BEAT_BITS-1:0]     beat_cnt;
    logic [WAY_BITS-1:0]      victim_ptr;

    assign line_if1 = line_of(miss_addr_if1);
    assign line_if2 = line_of(miss_addr_if2);

    // The in-flight line stays at the MSHR head until DONE, so the CAM covers it too.
    always_comb begin
        merge_if1      = |match_if1;
        merge_if2      = |match_if2;
        same_line      = (line_if1 == line_if2);
        miss_ready_if1 = running && (!full || merge_if1);
        take_if1       = miss_valid_if1 && miss_ready_if1;
        alloc_if1      = take_if1 && !merge_if1;
        miss_ready_if2 = running && ((free_cnt >= CNT_BITS'(2))
                                     || ((free_cnt == CNT_BITS'(1)) && !alloc_if1)
                                     || merge_if2
                                     || (take_if1 && same_line));
        alloc_if2      = miss_valid_if2 && miss_ready_if2 && !merge_if2
                         && !(miss_valid_if1 && same_line);
        more_after_pop = (free_cnt != CNT_BITS'(MSHR_ENTRIES - 1)) || alloc_if1 || alloc_if2;
        pop            = (state == DONE);
        beat           = (state == FILL) && l2_resp_valid;
    end

    l1i_mshr_fifo #(
        .ENTRIES (MSHR_ENTRIES)
    ) u_mshr (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_a      (alloc_if1),
        .push_a_addr (line_if1),
        .push_b      (alloc_if2),
        .push_b_addr (line_if2),
        .pop         (pop),
        .lookup_a    (line_if1),
        .lookup_b    (line_if2),
        .head        (head),
        .full        (full),
        .free_cnt    (free_cnt),
        .match_a     (match_if1),
        .match_b     (match_if2)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            victim_ptr     <= '0;
            fill_done      <= 1'b0;
            fill_done_addr <= '0;
            running        <= 1'b0;
        end else begin
            running   <= 1'b1;
            fill_done <= 1'b0;
            case (state)
                IDLE: if (head.valid) state <= REQ;
                REQ:  if (l2_req_ready) state <= FILL;
                FILL: if (l2_resp_valid) begin
                    if (beat_cnt == BEAT_BITS'(BEATS - 1)) begin
                        beat_cnt       <= '0;
                        state          <= DONE;
                        fill_done      <= 1'b1;
                        fill_done_addr <= head.line_addr;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                DONE: begin
                    victim_ptr <= (victim_ptr == WAY_BITS'(ASSOC - 1)) ? '0 : victim_ptr + 1'b1;
                    state      <= more_after_pop ? REQ : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        l2_req_valid = (state == REQ);
        l2_req_addr  = l2_req_valid ? head.line_addr : '0;
        fill_valid   = beat;
        fill_data    = beat ? l2_resp_data : '0;
        fill_word    = beat ? beat_cnt : '0;
        fill_way     = beat ? victim_ptr : '0;
        fill_set     = beat ? head.line_addr[OFFSET_BITS +: INDEX_BITS] : '0;
        fill_tag     = beat ? head.line_addr[ADDR_BITS-1 -: TAG_BITS] : '0;
        busy         = head.valid || (state != IDLE);
    end

    a_last_on_final_beat: assert property (@(posedge clk) disable iff (!rst_n)
        (state == FILL && l2_resp_valid) |-> (l2_resp_last == (beat_cnt == BEAT_BITS'(BEATS - 1))));

    a_resp_only_in_fill: assert property (@(posedge clk) disable iff (!rst_n)
        l2_resp_valid |-> (state == FILL));

endmodule

// File: tb/tb_l1_icache_refill_ctrl.sv
// Directed self-checking bench for the L1 I-cache refill controller.
module tb_l1_icache_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         miss_valid_if1;
    logic [63:0]  miss_addr_if1;
    logic         miss_ready_if1;
    logic         miss_valid_if2;
    logic [63:0]  miss_addr_if2;
    logic         miss_ready_if2;
    logic         l2_req_valid;
    logic [63:0]  l2_req_addr;
    logic         l2_req_ready;
    logic         l2_resp_valid;
    logic [63:0]  l2_resp_data;
    logic         l2_resp_last;
    logic         fill_valid;
    logic [6:0]   fill_set;
    logic [2:0]   fill_way;
    logic [2:0]   fill_word;
    logic [50:0]  fill_tag;
    logic [63:0]  fill_data;
    logic         fill_done;
    logic [63:0]  fill_done_addr;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    l1_icache_refill_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .miss_valid_if1 (miss_valid_if1),
        .miss_addr_if1  (miss_addr_if1),
        .miss_ready_if1 (miss_ready_if1),
        .miss_valid_if2 (miss_valid_if2),
        .miss_addr_if2  (miss_addr_if2),
        .miss_ready_if2 (miss_ready_if2),
        .l2_req_valid   (l2_req_valid),
        .l2_req_addr    (l2_req_addr),
        .l2_req_ready   (l2_req_ready),
        .l2_resp_valid  (l2_resp_valid),
        .l2_resp_data   (l2_resp_data),
        .l2_resp_last   (l2_resp_last),
        .fill_valid     (fill_valid),
        .fill_set       (fill_set),
        .fill_way       (fill_way),
        .fill_word      (fill_word),
        .fill_tag       (fill_tag),
        .fill_data      (fill_data),
        .fill_done      (fill_done),
        .fill_done_addr (fill_done_addr),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input logic [63:0] line, input int i);
        return {line[31:0], 32'hC0DE_0000 | 32'(i)};
    endfunction

    task automatic check_all_zero(input string pfx);
        chk({pfx, "_req_valid"}, l2_req_valid, 0);
        chk({pfx, "_req_addr"}, l2_req_addr, 0);
        chk({pfx, "_fill_valid"}, fill_valid, 0);
        chk({pfx, "_fill_data"}, fill_data, 0);
        chk({pfx, "_fill_word"}, fill_word, 0);
        chk({pfx, "_fill_done"}, fill_done, 0);
        chk({pfx, "_done_addr"}, fill_done_addr, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_ready1"}, miss_ready_if1, 0);
        chk({pfx, "_ready2"}, miss_ready_if2, 0);
    endtask

    task automatic send_miss1(input logic [63:0] addr);
        miss_valid_if1 = 1'b1;
        miss_addr_if1  = addr;
        #1;
        chk("miss1_ready", miss_ready_if1, 1);
        tick();
        miss_valid_if1 = 1'b0;
    endtask

    // Serves one line; returns in the DONE cycle, or with rst_n low right after beat abort_at.
    task automatic serve_line(input logic [63:0] line, input logic [2:0] way, input int abort_at);
        int budget = 0;
        while (!l2_req_valid && budget < 50) begin
            tick();
            budget++;
        end
        chk("req_seen", l2_req_valid, 1);
        if (!l2_req_valid) return;
        chk("req_addr", l2_req_addr, line);
        l2_req_ready = 1'b1;
        tick();
        l2_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            l2_resp_valid = 1'b1;
            l2_resp_data  = beat_data(line, i);
            l2_resp_last  = (i == 7);
            #1;
            chk("fill_valid", fill_valid, 1);
            chk("fill_word", fill_word, 64'(i));
            chk("fill_data", fill_data, beat_data(line, i));
            chk("fill_set", fill_set, (line >> 6) & 64'h7f);
            chk("fill_tag", fill_tag, line >> 13);
            chk("fill_way", fill_way, way);
            chk("fill_done_early", fill_done, 0);
            if (i == abort_at) begin
                rst_n         = 1'b0;
                l2_resp_valid = 1'b0;
                l2_resp_last  = 1'b0;
                return;
            end
            tick();
        end
        l2_resp_valid = 1'b0;
        l2_resp_last  = 1'b0;
        #1;
        chk("fill_done", fill_done, 1);
        chk("fill_done_addr", fill_done_addr, line);
        chk("no_fill_in_done", fill_valid, 0);
    endtask

    initial begin
        int budget;
        rst_n          = 1'b0;
        miss_valid_if1 = 1'b0;
        miss_addr_if1  = '0;
        miss_valid_if2 = 1'b0;
        miss_addr_if2  = '0;
        l2_req_ready   = 1'b0;
        l2_resp_valid  = 1'b0;
        l2_resp_data   = '0;
        l2_resp_last   = 1'b0;
        repeat (3) tick();
        check_all_zero("rst");
        rst_n = 1'b1;
        tick();
        tick();

        // Single miss: request appears two cycles after the miss
        miss_valid_if1 = 1'b1;
        miss_addr_if1  = 64'h1040;
        #1;
        chk("t1_ready", miss_ready_if1, 1);
        tick();
        miss_valid_if1 = 1'b0;
        chk("t1_req_n1", l2_req_valid, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_req_n2", l2_req_valid, 1);
        chk("t1_set_const", (64'h1040 >> 6) & 64'h7f, 64'h41);
        serve_line(64'h1040, 3'd0, 8);
        tick();
        chk("t1_idle_busy", busy, 0);
        chk("t1_done_pulse", fill_done, 0);

        // Same-line misses on both ports in one cycle
        miss_valid_if1 = 1'b1;
        miss_addr_if1  = 64'h2000;
        miss_valid_if2 = 1'b1;
        miss_addr_if2  = 64'h2038;
        #1;
        chk("t2_ready1", miss_ready_if1, 1);
        chk("t2_ready2", miss_ready_if2, 1);
        tick();
        miss_valid_if1 = 1'b0;
        miss_valid_if2 = 1'b0;
        serve_line(64'h2000, 3'd1, 8);
        tick();
        chk("t2_single_req", l2_req_valid, 0);
        chk("t2_idle", busy, 0);

        // Fill all four MSHR entries, then probe full behaviour
        miss_valid_if1 = 1'b1;
        miss_addr_if1  = 64'h3000;
        miss_valid_if2 = 1'b1;
        miss_addr_if2  = 64'h3040;
        #1;
        chk("t3_ready1_a", miss_ready_if1, 1);
        chk("t3_ready2_b", miss_ready_if2, 1);
        tick();
        miss_addr_if1 = 64'h3080;
        miss_addr_if2 = 64'h30C0;
        #1;
        chk("t3_ready1_c", miss_ready_if1, 1);
        chk("t3_ready2_d", miss_ready_if2, 1);
        tick();
        miss_addr_if1 = 64'h3100;
        miss_addr_if2 = 64'h3088;
        #1;
        chk("t3_full_ready1", miss_ready_if1, 0);
        chk("t3_merge_ready2", miss_ready_if2, 1);
        chk("t3_req_a", l2_req_addr, 64'h3000);
        miss_valid_if1 = 1'b0;
        miss_addr_if2  = 64'h3100;
        #1;
        chk("t3_full_ready2", miss_ready_if2, 0);
        miss_valid_if2 = 1'b0;
        serve_line(64'h3000, 3'd2, 8);
        miss_valid_if1 = 1'b1;
        miss_addr_if1  = 64'h3100;
        #1;
        chk("t3_done_ready1", miss_ready_if1, 0);
        tick();
        chk("t3_b_req_next", l2_req_valid, 1);
        chk("t3_b_addr", l2_req_addr, 64'h3040);
        miss_valid_if2 = 1'b1;
        miss_addr_if2  = 64'h3140;
        #1;
        chk("t3_last_slot1", miss_ready_if1, 1);
        chk("t3_last_slot2", miss_ready_if2, 0);
        tick();
        miss_valid_if1 = 1'b0;
        miss_valid_if2 = 1'b0;
        serve_line(64'h3040, 3'd3, 8);
        tick();
        serve_line(64'h3080, 3'd4, 8);
        tick();
        serve_line(64'h30C0, 3'd5, 8);
        tick();
        serve_line(64'h3100, 3'd6, 8);
        tick();
        chk("t3_idle", busy, 0);
        chk("t3_f_dropped", l2_req_valid, 0);

        // L2 stalls the request for ten cycles
        send_miss1(64'h4000);
        budget = 0;
        while (!l2_req_valid && budget < 20) begin
            tick();
            budget++;
        end
        for (int i = 0; i < 10; i++) begin
            chk("t4_valid_held", l2_req_valid, 1);
            chk("t4_addr_held", l2_req_addr, 64'h4000);
            chk("t4_no_fill", fill_valid, 0);
            tick();
        end
        serve_line(64'h4000, 3'd7, 8);
        tick();

        // Reset in the middle of a refill, then a fresh miss
        send_miss1(64'h5080);
        serve_line(64'h5080, 3'd0, 3);
        tick();
        check_all_zero("t5");
        rst_n = 1'b1;
        tick();
        tick();
        send_miss1(64'hFEDC_BA98_7654_3217);
        serve_line(64'hFEDC_BA98_7654_3200, 3'd0, 8);
        tick();
        chk("t5_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
